// File: rtl/mem_wb_stage_pkg.sv
// Shared MIPS definitions for the MEM/WB stage: load-type encodings, the
// `undefined` data value, REG_ZERO and the packed W-stage register layout.
package mem_wb_stage_pkg;

   typedef enum logic [2:0] {
      LT_LW  = 3'd0,
      LT_LB  = 3'd1,
      LT_LBU = 3'd2,
      LT_LH  = 3'd3,
      LT_LHU = 3'd4
   } load_type_e;

   localparam logic [31:0] UNDEFINED = 32'hxxxx_xxxx;
   localparam logic [4:0]  REG_ZERO  = 5'd0;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [4:0]  write_reg;
      logic [31:0] result;
      logic        align_err;
   } w_state_t;

   localparam w_state_t W_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// Big-endian load-width extraction with sign/zero extension and alignment check.
// LOAD_SUBWORD_EN builds LB/LBU/LH/LHU support; otherwise every load is an LW.
module load_extract
   import mem_wb_stage_pkg::*;
(
   input  logic [31:0] rd,
   input  logic [1:0]  ofs,
   input  logic [2:0]  load_type,
   output logic [31:0] data,
   output logic        misaligned
);

`ifdef LOAD_SUBWORD_EN
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      byte_sel   = rd[31:24];
      half_sel   = ofs[1] ? rd[15:0] : rd[31:16];
      data       = rd;
      misaligned = 1'b0;

      case (ofs)
         2'd0:    byte_sel = rd[31:24];
         2'd1:    byte_sel = rd[23:16];
         2'd2:    byte_sel = rd[15:8];
         default: byte_sel = rd[7:0];
      endcase

      case (load_type)
         LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LT_LBU:  data = {24'd0, byte_sel};
         LT_LH: begin
            data       = {{16{half_sel[15]}}, half_sel};
            misaligned = ofs[0];
         end
         LT_LHU: begin
            data       = {16'd0, half_sel};
            misaligned = ofs[0];
         end
         // LW and any unassigned encoding behave as a full-word load.
         default: misaligned = (ofs != 2'd0);
      endcase
   end
`else
   logic unused_load_type;

   assign unused_load_type = ^load_type;
   assign data             = rd;
   assign misaligned       = (ofs != 2'd0);
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction, writeback select, retired count.
// Sub-word loads are built only when LOAD_SUBWORD_EN is defined.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        StallW,
   input  logic        FlushW,
   input  logic        ValidM,
   input  logic        RegWriteM,
   input  logic        MemToRegM,
   input  logic [2:0]  LoadTypeM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] ReadDataM,
   input  logic [4:0]  WriteRegM,
   output logic        ValidW,
   output logic        RegWriteW,
   output logic [4:0]  WriteRegW,
   output logic [31:0] ResultW,
   output logic        AlignErrW,
   output logic [31:0] RetiredCount
);

   w_state_t    w_q, w_d;
   logic [31:0] retired_q;
   logic [31:0] load_data;
   logic        load_misaligned;
   logic        misaligned;

   load_extract u_load_extract (
      .rd         (ReadDataM),
      .ofs        (ALUOutM[1:0]),
      .load_type  (LoadTypeM),
      .data       (load_data),
      .misaligned (load_misaligned)
   );

   // Alignment only matters when memory data is actually written back.
   assign misaligned = MemToRegM & load_misaligned;

   always_comb begin
      w_d = W_BUBBLE;
      if (ValidM && !FlushW) begin
         w_d.valid     = 1'b1;
         w_d.align_err = misaligned;
         w_d.reg_write = RegWriteM & ~misaligned & (WriteRegM != REG_ZERO);
         w_d.write_reg = WriteRegM;
         // The select is always known, so an undefined ReadDataM never leaks on ALU ops.
         if (!MemToRegM)
            w_d.result = ALUOutM;
         else if (!misaligned)
            w_d.result = load_data;
         else
            w_d.result = 32'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         w_q       <= W_BUBBLE;
         retired_q <= 32'd0;
      end else if (!StallW) begin
         w_q <= w_d;
         if (w_d.valid)
            retired_q <= retired_q + 32'd1;
      end
   end

   assign ValidW       = w_q.valid;
   assign RegWriteW    = w_q.reg_write;
   assign WriteRegW    = w_q.write_reg;
   assign ResultW      = w_q.result;
   assign AlignErrW    = w_q.align_err;
   assign RetiredCount = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; expectations follow the
// LOAD_SUBWORD_EN setting of the build.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        StallW = 1'b0;
   logic        FlushW = 1'b0;
   logic        ValidM = 1'b0;
   logic        RegWriteM = 1'b0;
   logic        MemToRegM = 1'b0;
   logic [2:0]  LoadTypeM = 3'd0;
   logic [31:0] ALUOutM = 32'd0;
   logic [31:0] ReadDataM = 32'd0;
   logic [4:0]  WriteRegM = 5'd0;
   logic        ValidW;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic        AlignErrW;
   logic [31:0] RetiredCount;

   int errors = 0;
   int checks = 0;

   // {ValidW, RegWriteW, WriteRegW, ResultW, AlignErrW}
   logic [39:0] w_obs;
   logic [39:0] exp_w;
   logic [31:0] exp_cnt;

   assign w_obs = {ValidW, RegWriteW, WriteRegW, ResultW, AlignErrW};

   mem_wb_stage dut (
      .CLK          (CLK),
      .RST          (RST),
      .StallW       (StallW),
      .FlushW       (FlushW),
      .ValidM       (ValidM),
      .RegWriteM    (RegWriteM),
      .MemToRegM    (MemToRegM),
      .LoadTypeM    (LoadTypeM),
      .ALUOutM      (ALUOutM),
      .ReadDataM    (ReadDataM),
      .WriteRegM    (WriteRegM),
      .ValidW       (ValidW),
      .RegWriteW    (RegWriteW),
      .WriteRegW    (WriteRegW),
      .ResultW      (ResultW),
      .AlignErrW    (AlignErrW),
      .RetiredCount (RetiredCount)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                        input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr);
      ValidM    = v;
      RegWriteM = rw;
      MemToRegM = m2r;
      LoadTypeM = lt;
      ALUOutM   = alu;
      ReadDataM = rd;
      WriteRegM = wr;
   endtask

   task automatic test_reset();
      #1;
      exp_w = 40'd0;
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL reset_w: got %h want %h", w_obs, exp_w);
      end
      checks++;
      if (RetiredCount !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %h want 0", RetiredCount);
      end
      #2 RST = 1'b0;
   endtask

   task automatic test_lb();
      drive(1'b1, 1'b1, 1'b1, LT_LB, 32'h0000_0402, 32'h1234_80FF, 5'd8);
      tick();
`ifdef LOAD_SUBWORD_EN
      exp_w = {1'b1, 1'b1, 5'd8, 32'hFFFF_FF80, 1'b0};
`else
      exp_w = {1'b1, 1'b0, 5'd8, 32'h0000_0000, 1'b1};
`endif
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL lb_ofs2: got %h want %h", w_obs, exp_w);
      end
   endtask

   task automatic test_halfword();
      drive(1'b1, 1'b1, 1'b1, LT_LHU, 32'h0000_0402, 32'h1234_80FF, 5'd9);
      tick();
`ifdef LOAD_SUBWORD_EN
      exp_w = {1'b1, 1'b1, 5'd9, 32'h0000_80FF, 1'b0};
`else
      exp_w = {1'b1, 1'b0, 5'd9, 32'h0000_0000, 1'b1};
`endif
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL lhu_ofs2: got %h want %h", w_obs, exp_w);
      end
      drive(1'b1, 1'b1, 1'b1, LT_LH, 32'h0000_0401, 32'h1234_80FF, 5'd10);
      tick();
      exp_w = {1'b1, 1'b0, 5'd10, 32'h0000_0000, 1'b1};
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL lh_misaligned: got %h want %h", w_obs, exp_w);
      end
      checks++;
      if (RetiredCount !== 32'd3) begin
         errors++;
         $display("FAIL lh_misaligned_cnt: got %0d want 3", RetiredCount);
      end
   endtask

   task automatic test_lw();
      drive(1'b1, 1'b1, 1'b1, LT_LW, 32'h0000_0400, 32'hCAFE_F00D, 5'd11);
      tick();
      exp_w = {1'b1, 1'b1, 5'd11, 32'hCAFE_F00D, 1'b0};
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL lw_aligned: got %h want %h", w_obs, exp_w);
      end
      drive(1'b1, 1'b1, 1'b1, LT_LW, 32'h0000_0403, 32'hCAFE_F00D, 5'd12);
      tick();
      exp_w = {1'b1, 1'b0, 5'd12, 32'h0000_0000, 1'b1};
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL lw_ofs3: got %h want %h", w_obs, exp_w);
      end
   endtask

   task automatic test_alu_op();
      drive(1'b1, 1'b1, 1'b0, LT_LB, 32'hDEAD_BEEF, UNDEFINED, 5'd3);
      tick();
      exp_w = {1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0};
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL alu_op: got %h want %h", w_obs, exp_w);
      end
      drive(1'b1, 1'b1, 1'b0, LT_LB, 32'hDEAD_BEEF, UNDEFINED, 5'd0);
      tick();
      exp_w = {1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0};
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL alu_reg0: got %h want %h", w_obs, exp_w);
      end
      // Unaligned ALU result is not a load, so no alignment error.
      drive(1'b1, 1'b1, 1'b0, LT_LW, 32'h0000_0003, 32'h5555_5555, 5'd4);
      tick();
      exp_w = {1'b1, 1'b1, 5'd4, 32'h0000_0003, 1'b0};
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL alu_unaligned: got %h want %h", w_obs, exp_w);
      end
      checks++;
      if (RetiredCount !== 32'd8) begin
         errors++;
         $display("FAIL alu_cnt: got %0d want 8", RetiredCount);
      end
   endtask

   task automatic test_stall();
      exp_w   = {1'b1, 1'b1, 5'd4, 32'h0000_0003, 1'b0};
      exp_cnt = 32'd8;
      StallW  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, LT_LW, 32'h1000_0000 + i, 32'd0, 5'd20 + 5'(i));
         FlushW = (i == 2);
         tick();
         checks++;
         if (w_obs !== exp_w) begin
            errors++;
            $display("FAIL stall_w[%0d]: got %h want %h", i, w_obs, exp_w);
         end
         checks++;
         if (RetiredCount !== exp_cnt) begin
            errors++;
            $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, RetiredCount, exp_cnt);
         end
      end
      StallW = 1'b0;
      FlushW = 1'b0;
   endtask

   task automatic test_flush();
      FlushW = 1'b1;
      drive(1'b1, 1'b1, 1'b0, LT_LW, 32'h1234_5678, 32'd0, 5'd7);
      tick();
      FlushW = 1'b0;
      checks++;
      if (w_obs !== 40'd0) begin
         errors++;
         $display("FAIL flush_bubble: got %h want 0", w_obs);
      end
      checks++;
      if (RetiredCount !== 32'd8) begin
         errors++;
         $display("FAIL flush_cnt: got %0d want 8", RetiredCount);
      end
      drive(1'b0, 1'b1, 1'b0, LT_LW, 32'h1234_5678, 32'd0, 5'd7);
      tick();
      checks++;
      if ({w_obs, RetiredCount} !== {40'd0, 32'd8}) begin
         errors++;
         $display("FAIL invalid_bubble: got %h/%0d want 0/8", w_obs, RetiredCount);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b1, 1'b1, LT_LBU, 32'h0000_0403, 32'h1234_80FF, 5'd6);
      tick();
`ifdef LOAD_SUBWORD_EN
      exp_w = {1'b1, 1'b1, 5'd6, 32'h0000_00FF, 1'b0};
`else
      exp_w = {1'b1, 1'b0, 5'd6, 32'h0000_0000, 1'b1};
`endif
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL b2b_lbu: got %h want %h", w_obs, exp_w);
      end
      drive(1'b1, 1'b1, 1'b1, LT_LB, 32'h0000_0400, 32'h1234_80FF, 5'd7);
      tick();
`ifdef LOAD_SUBWORD_EN
      exp_w = {1'b1, 1'b1, 5'd7, 32'h0000_0012, 1'b0};
`else
      exp_w = {1'b1, 1'b1, 5'd7, 32'h1234_80FF, 1'b0};
`endif
      checks++;
      if (w_obs !== exp_w) begin
         errors++;
         $display("FAIL b2b_lb: got %h want %h", w_obs, exp_w);
      end
      checks++;
      if (RetiredCount !== 32'd10) begin
         errors++;
         $display("FAIL b2b_cnt: got %0d want 10", RetiredCount);
      end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b0, 1'b0, LT_LW, 32'd0, 32'd0, 5'd0);
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      #1;
      checks++;
      if (RetiredCount !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_preload: got %h want ffffffff", RetiredCount);
      end
      drive(1'b1, 1'b1, 1'b0, LT_LW, 32'h0000_0042, 32'd0, 5'd2);
      tick();
      checks++;
      if (RetiredCount !== 32'd0) begin
         errors++;
         $display("FAIL wrap_zero: got %h want 0", RetiredCount);
      end
      tick();
      checks++;
      if (RetiredCount !== 32'd1) begin
         errors++;
         $display("FAIL wrap_one: got %h want 1", RetiredCount);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b1, 1'b0, LT_LW, 32'h0000_0077, 32'd0, 5'd5);
      tick();
      StallW = 1'b1;
      FlushW = 1'b1;
      #2 RST = 1'b1;
      #1;
      checks++;
      if ({w_obs, RetiredCount} !== 72'd0) begin
         errors++;
         $display("FAIL async_reset: got %h/%h want 0/0", w_obs, RetiredCount);
      end
      @(negedge CLK);
      RST    = 1'b0;
      StallW = 1'b0;
      FlushW = 1'b0;
      tick();
      exp_w = {1'b1, 1'b1, 5'd5, 32'h0000_0077, 1'b0};
      checks++;
      if ({w_obs, RetiredCount} !== {exp_w, 32'd1}) begin
         errors++;
         $display("FAIL post_reset_capture: got %h/%0d want %h/1", w_obs, RetiredCount, exp_w);
      end
   endtask

   initial begin
      test_reset();
      @(negedge CLK);
      test_lb();
      test_halfword();
      test_lw();
      test_alu_op();
      test_stall();
      test_flush();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback-select stage of the pipelined MIPS core. It sits directly downstream of the data Memory block: it captures the Memory read data (RD) together with the M-stage control and ALU result, performs load-width extraction and sign/zero extension, selects the writeback value, and presents a registered result to the register file and forwarding network. It also keeps a retired-instruction counter and flags misaligned loads.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  core clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- StallW  in  1  hold all W registers; counter does not advance.
- FlushW  in  1  load a bubble into W.
- ValidM  in  1  M-stage slot holds a real instruction.
- RegWriteM  in  1  instruction writes the register file.
- MemToRegM  in  1  1 = result from memory, 0 = from ALU.
- LoadTypeM  in  3  LT_LW, LT_LB, LT_LBU, LT_LH, LT_LHU (encodings from mips.h).
- ALUOutM  in  32  ALU result / effective address.
- ReadDataM  in  32  Memory RD for the same instruction.
- WriteRegM  in  5  destination register.
- ValidW  out  1  W slot holds a real instruction.
- RegWriteW  out  1  qualified register-file write enable.
- WriteRegW  out  5  destination register.
- ResultW  out  32  writeback value.
- AlignErrW  out  1  misaligned load retired this cycle.
- RetiredCount  out  32  count of retired valid instructions.

## Operation
- Capture condition: posedge CLK with StallW=0. Next W state is a bubble if FlushW=1 or ValidM=0; otherwise the processed M inputs.
- Bubble: ValidW=0, RegWriteW=0, WriteRegW=0, ResultW=0, AlignErrW=0.
- Byte offset ofs = ALUOutM[1:0], big-endian: byte 0 = ReadDataM[31:24], byte 3 = [7:0]; halfword 0 = [31:16], halfword 1 = [15:0].
- LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unchanged.
- Misalignment: LW with ofs≠0, LH/LHU with ofs[0]=1. When MemToRegM=1 and misaligned: AlignErrW=1, RegWriteW=0, ResultW=0, ValidW=1.
- MemToRegM=0: ResultW=ALUOutM; LoadTypeM and ReadDataM are ignored, and an `undefined` ReadDataM must not reach ResultW.
- RegWriteW = RegWriteM & ~misaligned & (WriteRegM≠0). Writes to $0 are suppressed; ResultW is still captured.
- RetiredCount increments by 1 on each capture that produces ValidW=1 (misaligned loads count). It wraps from 0xFFFF_FFFF to 0.

## Timing
- Latency: 1 cycle, M inputs to W outputs. All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (async assert, any phase): all outputs 0, RetiredCount=0. The first capture happens on the first posedge after RST deasserts.
- StallW=1: all outputs and RetiredCount hold, regardless of FlushW.
- StallW=0 with FlushW=1: bubble; counter does not increment.
- RST asserted mid-stall or mid-flush: reset wins immediately.
- W outputs stay stable for the full cycle; the register file writes them on the next edge and forwarding reads them combinationally.

## Configuration
- LOAD_SUBWORD_EN defined: full LB/LBU/LH/LHU extraction and halfword alignment checks as described above.
- LOAD_SUBWORD_EN undefined: every load is treated as LW. LoadTypeM is ignored. AlignErrW is set only for ofs≠0 when MemToRegM=1. The extraction logic is not built.

## Structure
- mips.h (shared): LT_* load-type encodings (3 bits), the `undefined` value, and the REG_ZERO constant.
- Sub-module load_extract: a combinational block taking (ReadDataM, ofs, LoadTypeM) and returning (data, misaligned). It is instantiated once. Its body is conditionally compiled under LOAD_SUBWORD_EN.
- Top level contains the capture register, bubble/stall logic, writeback mux and RetiredCount.

## Test plan
- Reset: assert RST asynchronously mid-cycle with valid data in W → all outputs 0 immediately; RetiredCount=0.
- LB: ALUOutM=0x402, ReadDataM=0x1234_80FF, LT_LB, MemToRegM=1, WriteRegM=8 → next cycle ResultW=0xFFFF_FF80, RegWriteW=1, WriteRegW=8.
- LHU at ofs 2 gives ResultW=0x0000_80FF; LH at ofs 1 gives AlignErrW=1, RegWriteW=0, and RetiredCount increments.
- ALU op: MemToRegM=0, ALUOutM=0xDEAD_BEEF, ReadDataM=`undefined` → ResultW=0xDEAD_BEEF with no X on the output. Same op with WriteRegM=0 → RegWriteW=0.
- Stall/flush: StallW=1 for 3 cycles with changing inputs → outputs and count frozen. StallW=0 with FlushW=1 → bubble and count unchanged. StallW=1 with FlushW=1 → hold.
- Counter wrap: preload via 2^32−1 retirements (force) then one more valid instruction → RetiredCount=0. Rebuild without LOAD_SUBWORD_EN: LB at ofs 2 → AlignErrW=1.
